// File: rtl/cmd_timing_gate.sv
// -----------------------------------------------------------------------------
// cmd_timing_gate
//
// Holds one DRAM command request at a time. The request is released as a
// one-cycle issue strobe once every timing constraint that applies to it
// is met. Per-bank constraints come from the per-bank timing counters
// (remaining count plus recode). The cross-bank ACT rules tRRD and tFAW
// are tracked locally, because no single bank counter can see them.
//
// Ports
//   clk          in   clock
//   rst_n        in   asynchronous active-low reset
//   req_valid    in   command request valid
//   req_cmd      in   0 NOP, 1 ACT, 2 READ, 3 WRITE, 4 PRE, 5 REF, 6-7 illegal
//   req_bank     in   target bank
//   req_ready    out  gate can accept a request this cycle
//   tp_cnt_flat  in   per-bank remaining count, bank b at [5b+4:5b]
//   recode_flat  in   per-bank recode, bank b at [3b+2:3b]
//   issue_valid  out  one-cycle issue strobe
//   issue_cmd    out  issued command (0 when issue_valid=0)
//   issue_bank   out  issued bank (0 when issue_valid=0)
//   cmd_err      out  one-cycle pulse when an illegal command is accepted
//   stall_cnt    out  cycles the current request has waited (saturating)
//
// Recode encodings (recode_state_t):
//   0 NONE, 1 WRITE_TO_PRECHARGE, 2 READ_TO_PRECHARGE, 3 PRECHARGE_TO_ACTIVE,
//   4 ACTIVE_TO_READ_WRITE, 5 PRECHARGE_TO_REFRESH, 6-7 unused (never block)
// -----------------------------------------------------------------------------
module cmd_timing_gate #(
    parameter int NUM_BANK = 8,
    parameter int BA_BITS  = 3,
    parameter int TRRD     = 4,
    parameter int TFAW     = 16,
    parameter int STALL_W  = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    input  logic [2:0]            req_cmd,
    input  logic [BA_BITS-1:0]    req_bank,
    output logic                  req_ready,
    input  logic [NUM_BANK*5-1:0] tp_cnt_flat,
    input  logic [NUM_BANK*3-1:0] recode_flat,
    output logic                  issue_valid,
    output logic [2:0]            issue_cmd,
    output logic [BA_BITS-1:0]    issue_bank,
    output logic                  cmd_err,
    output logic [STALL_W-1:0]    stall_cnt
);

    localparam logic [2:0] CMD_NOP   = 3'd0;
    localparam logic [2:0] CMD_ACT   = 3'd1;
    localparam logic [2:0] CMD_READ  = 3'd2;
    localparam logic [2:0] CMD_WRITE = 3'd3;
    localparam logic [2:0] CMD_PRE   = 3'd4;
    localparam logic [2:0] CMD_REF   = 3'd5;

    localparam logic [2:0] RC_WRITE_TO_PRECHARGE   = 3'd1;
    localparam logic [2:0] RC_READ_TO_PRECHARGE    = 3'd2;
    localparam logic [2:0] RC_PRECHARGE_TO_ACTIVE  = 3'd3;
    localparam logic [2:0] RC_ACTIVE_TO_READ_WRITE = 3'd4;
    localparam logic [2:0] RC_PRECHARGE_TO_REFRESH = 3'd5;

    localparam int TRRD_W = $clog2(TRRD + 1) + 1;
    localparam int TFAW_W = $clog2(TFAW + 1) + 1;
    localparam logic [TRRD_W-1:0] TRRD_LOAD = TRRD_W'(TRRD - 1);
    localparam logic [TFAW_W-1:0] TFAW_LOAD = TFAW_W'(TFAW - 1);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } state_t;

    // True when a bank whose counter is still running under recode rc
    // forbids command cmd.
    function automatic logic bank_blocks(input logic [2:0] cmd,
                                         input logic [4:0] tp,
                                         input logic [2:0] rc);
        logic hit;
        case (rc)
            RC_WRITE_TO_PRECHARGE:   hit = (cmd == CMD_PRE);
            RC_READ_TO_PRECHARGE:    hit = (cmd == CMD_PRE);
            RC_PRECHARGE_TO_ACTIVE:  hit = (cmd == CMD_ACT);
            RC_ACTIVE_TO_READ_WRITE: hit = (cmd == CMD_READ) || (cmd == CMD_WRITE);
            RC_PRECHARGE_TO_REFRESH: hit = (cmd == CMD_REF);
            default:                 hit = 1'b0;
        endcase
        return hit && (tp != 5'd0);
    endfunction

    state_t               state_r;
    state_t               state_nxt_s;
    logic [2:0]           held_cmd_r;
    logic [BA_BITS-1:0]   held_bank_r;
    logic                 ready_r;
    logic                 issue_valid_r;
    logic [2:0]           issue_cmd_r;
    logic [BA_BITS-1:0]   issue_bank_r;
    logic                 cmd_err_r;
    logic [STALL_W-1:0]   stall_cnt_r;
    logic [TRRD_W-1:0]    trrd_cnt_r;
    logic [TFAW_W-1:0]    faw_r [4];

    logic [NUM_BANK-1:0]  bank_blk_s;
    logic                 held_blk_s;
    logic                 any_blk_s;
    logic                 faw_free_s;
    logic [1:0]           faw_sel_s;
    logic                 clear_s;
    logic                 accept_s;
    logic                 err_s;
    logic                 issue_s;
    logic                 act_issue_s;

    // Per-bank block flags for the held command, and the ACT window resources.
    always_comb begin
        bank_blk_s = '0;
        for (int b = 0; b < NUM_BANK; b++) begin
            bank_blk_s[b] = bank_blocks(held_cmd_r, tp_cnt_flat[5*b +: 5],
                                        recode_flat[3*b +: 3]);
        end
        held_blk_s = bank_blk_s[held_bank_r];
        any_blk_s  = |bank_blk_s;
        faw_free_s = 1'b0;
        faw_sel_s  = 2'd0;
        // Walk downward so the lowest-index free timer wins.
        for (int i = 3; i >= 0; i--) begin
            if (faw_r[i] == '0) begin
                faw_free_s = 1'b1;
                faw_sel_s  = 2'(i);
            end else begin
                faw_free_s = faw_free_s;
            end
        end
    end

    // Clearance of the held command against its applicable rules.
    always_comb begin
        clear_s = 1'b0;
        case (held_cmd_r)
            CMD_ACT:   clear_s = !held_blk_s && (trrd_cnt_r == '0) && faw_free_s;
            CMD_READ,
            CMD_WRITE,
            CMD_PRE:   clear_s = !held_blk_s;
            CMD_REF:   clear_s = !any_blk_s;
            // Only legal commands are ever latched; release anything else
            // rather than hang.
            default:   clear_s = 1'b1;
        endcase
    end

    // Next-state and per-cycle event decode.
    always_comb begin
        state_nxt_s = state_r;
        accept_s    = 1'b0;
        err_s       = 1'b0;
        issue_s     = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (req_valid && (req_cmd >= CMD_ACT) && (req_cmd <= CMD_REF)) begin
                    accept_s    = 1'b1;
                    state_nxt_s = ST_WAIT;
                end else if (req_valid && (req_cmd > CMD_REF)) begin
                    err_s = 1'b1;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (clear_s) begin
                    issue_s     = 1'b1;
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_WAIT;
                end
            end
            default: state_nxt_s = ST_IDLE;
        endcase
        act_issue_s = issue_s && (held_cmd_r == CMD_ACT);
    end

    // State, held request and ready flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            held_cmd_r  <= CMD_NOP;
            held_bank_r <= '0;
            ready_r     <= 1'b1;
        end else begin
            state_r <= state_nxt_s;
            ready_r <= (state_nxt_s == ST_IDLE);
            if (accept_s) begin
                held_cmd_r  <= req_cmd;
                held_bank_r <= req_bank;
            end
        end
    end

    // Registered issue strobe, issued command/bank and error pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            issue_valid_r <= 1'b0;
            issue_cmd_r   <= CMD_NOP;
            issue_bank_r  <= '0;
            cmd_err_r     <= 1'b0;
        end else begin
            issue_valid_r <= issue_s;
            issue_cmd_r   <= issue_s ? held_cmd_r : CMD_NOP;
            issue_bank_r  <= issue_s ? held_bank_r : '0;
            cmd_err_r     <= err_s;
        end
    end

    // Saturating wait counter; held outside WAIT so the last wait stays visible.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_r <= '0;
        end else if (accept_s) begin
            stall_cnt_r <= '0;
        end else if ((state_r == ST_WAIT) && !clear_s && (stall_cnt_r != {STALL_W{1'b1}})) begin
            stall_cnt_r <= stall_cnt_r + STALL_W'(1);
        end else begin
            stall_cnt_r <= stall_cnt_r;
        end
    end

    // tRRD and tFAW timers: load on ACT issue, otherwise count down to zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            trrd_cnt_r <= '0;
            for (int i = 0; i < 4; i++) begin
                faw_r[i] <= '0;
            end
        end else begin
            if (act_issue_s) begin
                trrd_cnt_r <= TRRD_LOAD;
            end else if (trrd_cnt_r != '0) begin
                trrd_cnt_r <= trrd_cnt_r - TRRD_W'(1);
            end else begin
                trrd_cnt_r <= trrd_cnt_r;
            end
            for (int i = 0; i < 4; i++) begin
                if (act_issue_s && (faw_sel_s == 2'(i))) begin
                    faw_r[i] <= TFAW_LOAD;
                end else if (faw_r[i] != '0) begin
                    faw_r[i] <= faw_r[i] - TFAW_W'(1);
                end else begin
                    faw_r[i] <= faw_r[i];
                end
            end
        end
    end

    assign req_ready   = ready_r;
    assign issue_valid = issue_valid_r;
    assign issue_cmd   = issue_cmd_r;
    assign issue_bank  = issue_bank_r;
    assign cmd_err     = cmd_err_r;
    assign stall_cnt   = stall_cnt_r;

endmodule

// File: tb/tb_cmd_timing_gate.sv
// Testbench for cmd_timing_gate: timestamp-based reference model plus
// directed scenarios with hand-computed expectations.
module tb_cmd_timing_gate;

    localparam int TRRD = 4;
    localparam int TFAW = 16;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic [2:0]  req_cmd;
    logic [2:0]  req_bank;
    logic        req_ready;
    logic [39:0] tp_cnt_flat;
    logic [23:0] recode_flat;
    logic        issue_valid;
    logic [2:0]  issue_cmd;
    logic [2:0]  issue_bank;
    logic        cmd_err;
    logic [7:0]  stall_cnt;

    logic [4:0] tp [8];
    logic [2:0] rc [8];

    int checks = 0;
    int errors = 0;
    int tcyc   = 0;

    cmd_timing_gate #(.NUM_BANK(8), .BA_BITS(3), .TRRD(TRRD), .TFAW(TFAW), .STALL_W(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_cmd(req_cmd), .req_bank(req_bank), .req_ready(req_ready),
        .tp_cnt_flat(tp_cnt_flat), .recode_flat(recode_flat),
        .issue_valid(issue_valid), .issue_cmd(issue_cmd), .issue_bank(issue_bank),
        .cmd_err(cmd_err), .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    always @(posedge clk) tcyc <= tcyc + 1;

    always_comb begin
        tp_cnt_flat = '0;
        recode_flat = '0;
        for (int b = 0; b < 8; b++) begin
            tp_cnt_flat[5*b +: 5] = tp[b];
            recode_flat[3*b +: 3] = rc[b];
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, tcyc);
        end
    endtask

    // ---------------- reference model ----------------
    // Requests are tracked as "pending or not"; ACT history is a list of
    // issue-cycle timestamps, from which tRRD/tFAW clearance is derived.
    bit       m_pend;
    bit [2:0] m_hcmd;
    bit [2:0] m_hbank;
    bit       m_ready, m_iv, m_err;
    bit [2:0] m_icmd, m_ibank;
    int       m_stall;
    int       act_q[$];

    function automatic bit rc_targets(input bit [2:0] code, input bit [2:0] cmd);
        case (code)
            3'd1, 3'd2: return cmd == 3'd4;
            3'd3:       return cmd == 3'd1;
            3'd4:       return (cmd == 3'd2) || (cmd == 3'd3);
            3'd5:       return cmd == 3'd5;
            default:    return 1'b0;
        endcase
    endfunction

    function automatic bit model_clear(input int c);
        bit blk[8];
        int n;
        bit all_free;
        n = 0;
        all_free = 1'b1;
        for (int b = 0; b < 8; b++) begin
            blk[b] = (tp[b] != 5'd0) && rc_targets(rc[b], m_hcmd);
            if (blk[b]) all_free = 1'b0;
        end
        if (m_hcmd == 3'd5) return all_free;
        if (m_hcmd == 3'd1) begin
            if (act_q.size() > 0 && c < act_q[act_q.size()-1] + TRRD - 1) return 1'b0;
            foreach (act_q[i]) if (c < act_q[i] + TFAW - 1) n++;
            return !blk[m_hbank] && (n < 4);
        end
        return !blk[m_hbank];
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_pend <= 1'b0; m_ready <= 1'b1; m_iv <= 1'b0; m_icmd <= 3'd0;
            m_ibank <= 3'd0; m_err <= 1'b0; m_stall <= 0; m_hcmd <= 3'd0; m_hbank <= 3'd0;
            act_q.delete();
        end else begin
            m_iv <= 1'b0; m_icmd <= 3'd0; m_ibank <= 3'd0; m_err <= 1'b0;
            if (!m_pend) begin
                if (req_valid && req_cmd >= 3'd1 && req_cmd <= 3'd5) begin
                    m_pend <= 1'b1; m_hcmd <= req_cmd; m_hbank <= req_bank;
                    m_stall <= 0; m_ready <= 1'b0;
                end else if (req_valid && req_cmd >= 3'd6) begin
                    m_err <= 1'b1;
                end
            end else if (model_clear(tcyc)) begin
                m_iv <= 1'b1; m_icmd <= m_hcmd; m_ibank <= m_hbank;
                m_pend <= 1'b0; m_ready <= 1'b1;
                if (m_hcmd == 3'd1) act_q.push_back(tcyc + 1);
            end else if (m_stall != 255) begin
                m_stall <= m_stall + 1;
            end
        end
    end

    // Per-cycle comparison against the model.
    always @(negedge clk) begin
        if (rst_n) begin
            chk("req_ready",   int'(req_ready),   int'(m_ready));
            chk("issue_valid", int'(issue_valid), int'(m_iv));
            chk("issue_cmd",   int'(issue_cmd),   int'(m_icmd));
            chk("issue_bank",  int'(issue_bank),  int'(m_ibank));
            chk("cmd_err",     int'(cmd_err),     int'(m_err));
            chk("stall_cnt",   int'(stall_cnt),   m_stall);
        end
    end

    // ---------------- stimulus helpers ----------------
    // Called at posedge+2; returns at posedge+2 just after the accepting edge.
    task automatic send(input logic [2:0] cmd, input logic [2:0] bank, output int acc);
        acc = -1;
        req_valid = 1'b1; req_cmd = cmd; req_bank = bank;
        for (int i = 0; i < 200; i++) begin
            if (req_ready) begin
                acc = tcyc;
                @(posedge clk); #2;
                req_valid = 1'b0; req_cmd = 3'd0; req_bank = 3'd0;
                return;
            end
            @(posedge clk); #2;
        end
        req_valid = 1'b0; req_cmd = 3'd0; req_bank = 3'd0;
        checks++; errors++;
        $display("FAIL accept_timeout: request cmd %0d never accepted", cmd);
    endtask

    task automatic wait_issue(output int t, output int st, output int c, output int b);
        t = -1; st = -1; c = -1; b = -1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (issue_valid) begin
                t = tcyc; st = int'(stall_cnt); c = int'(issue_cmd); b = int'(issue_bank);
                return;
            end
        end
        checks++; errors++;
        $display("FAIL issue_timeout: no issue_valid within 200 cycles");
    endtask

    initial begin
        int acc, t, st, c, b, z;
        int ta[5];
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc, t, st, c, b, z;
        int ta[5];
        rst_n = 1'b0; req_valid = 1'b0; req_cmd = 3'd0; req_bank = 3'd0;
        for (int i = 0; i < 8; i++) begin tp[i] = 5'd0; rc[i] = 3'd0; end
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        chk("reset_ready", int'(req_ready), 1);
        chk("reset_issue_valid", int'(issue_valid), 0);
        chk("reset_stall", int'(stall_cnt), 0);

        // Reset while an ACT is held and blocked.
        @(posedge clk); #2;
        tp[0] = 5'd10; rc[0] = 3'd3;
        send(3'd1, 3'd0, acc);
        repeat (3) begin @(posedge clk); #2; end
        chk("held_ready_low", int'(req_ready), 0);
        rst_n = 1'b0;
        #1;
        chk("rst_async_ready", int'(req_ready), 1);
        chk("rst_async_stall", int'(stall_cnt), 0);
        @(negedge clk);
        chk("rst_no_issue", int'(issue_valid), 0);
        @(posedge clk); #2;
        rst_n = 1'b1; tp[0] = 5'd0; rc[0] = 3'd0;
        @(negedge clk);
        chk("rst_rel_ready", int'(req_ready), 1);
        chk("rst_rel_stall", int'(stall_cnt), 0);
        chk("rst_rel_cmd", int'(issue_cmd), 0);
        repeat (3) begin
            @(negedge clk);
            chk("rst_discard", int'(issue_valid), 0);
        end

        // READ bank 2 held by ACTIVE_TO_READ_WRITE counting 3,2,1,0.
        @(posedge clk); #2;
        tp[2] = 5'd3; rc[2] = 3'd4;
        send(3'd2, 3'd2, acc);
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #2;
            tp[2] = tp[2] - 5'd1;
        end
        z = tcyc;
        wait_issue(t, st, c, b);
        chk("read_issue_time", t, z + 1);
        chk("read_cmd", c, 2);
        chk("read_bank", b, 2);
        chk("read_stall", st, 3);
        rc[2] = 3'd0;

        // PRE bank 1: recode does not target PRE, so no block.
        @(posedge clk); #2;
        tp[1] = 5'd5; rc[1] = 3'd4;
        send(3'd4, 3'd1, acc);
        wait_issue(t, st, c, b);
        chk("pre_latency", t - acc, 2);
        chk("pre_stall", st, 0);
        chk("pre_cmd", c, 4);
        chk("pre_bank", b, 1);
        tp[1] = 5'd0; rc[1] = 3'd0;

        // Five ACTs: tRRD spacing, then tFAW window.
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #2;
            send(3'd1, 3'(i), acc);
            wait_issue(ta[i], st, c, b);
            chk("act_bank", b, i);
            chk("act_cmd", c, 1);
        end
        for (int i = 0; i < 3; i++) chk("act_trrd_gap", ta[i+1] - ta[i], 4);
        chk("act_tfaw_gap", ta[4] - ta[0], 16);

        // REF blocked only by bank 7 under PRECHARGE_TO_REFRESH.
        @(posedge clk); #2;
        tp[7] = 5'd2; rc[7] = 3'd5;
        send(3'd5, 3'd0, acc);
        @(posedge clk); #2; tp[7] = 5'd1;
        @(posedge clk); #2; tp[7] = 5'd0;
        z = tcyc;
        wait_issue(t, st, c, b);
        chk("ref_issue_time", t, z + 1);
        chk("ref_cmd", c, 5);
        chk("ref_bank", b, 0);
        chk("ref_stall", st, 2);
        rc[7] = 3'd0;

        // Illegal command 6, then 7, then NOP.
        for (int k = 6; k < 8; k++) begin
            @(posedge clk); #2;
            req_valid = 1'b1; req_cmd = 3'(k); req_bank = 3'd3;
            @(posedge clk); #2;
            req_valid = 1'b0; req_cmd = 3'd0; req_bank = 3'd0;
            @(negedge clk);
            chk("illegal_err", int'(cmd_err), 1);
            chk("illegal_ready", int'(req_ready), 1);
            chk("illegal_no_issue", int'(issue_valid), 0);
            @(negedge clk);
            chk("illegal_err_pulse", int'(cmd_err), 0);
        end
        @(posedge clk); #2;
        req_valid = 1'b1; req_cmd = 3'd0; req_bank = 3'd5;
        @(posedge clk); #2;
        req_valid = 1'b0;
        @(negedge clk);
        chk("nop_ready", int'(req_ready), 1);
        chk("nop_err", int'(cmd_err), 0);
        chk("nop_issue", int'(issue_valid), 0);

        repeat (3) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
